// File: rtl/io_xbar_out_arb.sv
// -----------------------------------------------------------------------------
// io_xbar_out_arb
//
// Round-robin output-port arbiter for the chipset I/O crossbar. Only inputs
// whose head flit is addressed to MY_DEST compete. Once a header flit is
// accepted, the grant is held for the whole packet (header + LEN payload
// flits), so packets from different inputs are never interleaved on the output.
//
// Optional feature: define IO_XBAR_ARB_WATCHDOG_EN to add a stall watchdog
// that raises a sticky wdog_err when a locked packet makes no progress for
// 2^WDOG_BITS-1 cycles. Without the macro wdog_err is a constant 0.
//
// Ports:
//   clk       in   clock, all state on the rising edge
//   rst_n     in   synchronous active-low reset
//   in_data   in   NUM_IN flits, port i at [i*WIDTH +: WIDTH]
//   in_val    in   per-input flit valid
//   in_rdy    out  per-input flit accept (combinational from out_rdy)
//   out_data  out  selected flit (combinational)
//   out_val   out  output flit valid
//   out_rdy   in   downstream accept
//   grant_id  out  winning input (IDLE) or packet owner (LOCKED)
//   locked    out  high while a packet's payload is in flight
//   wdog_err  out  sticky stall error
// -----------------------------------------------------------------------------
module io_xbar_out_arb #(
  parameter int NUM_IN     = 4,
  parameter int WIDTH      = 64,
  parameter int DEST_LSB   = 50,
  parameter int DEST_WIDTH = 8,
  parameter int MY_DEST    = 0,
  parameter int LEN_LSB    = 22,
  parameter int LEN_WIDTH  = 8,
  parameter int WDOG_BITS  = 10,
  localparam int IDW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_val,
  output logic [NUM_IN-1:0]       in_rdy,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [IDW-1:0]          grant_id,
  output logic                    locked,
  output logic                    wdog_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q,    state_d;
  logic [LEN_WIDTH-1:0] cnt_q,      cnt_d;
  logic [IDW-1:0]       last_ptr_q, last_ptr_d;
  logic [IDW-1:0]       gnt_q,      gnt_d;

  logic [WIDTH-1:0]     flit [NUM_IN];
  logic [NUM_IN-1:0]    req;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       sel;
  logic [LEN_WIDTH-1:0] hdr_len;

  // (base + k) mod NUM_IN without a divider; k never exceeds NUM_IN.
  function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] base, int unsigned k);
    logic [IDW:0] sum;
    sum = {1'b0, base} + (IDW+1)'(k);
    if (sum >= (IDW+1)'(NUM_IN)) sum = sum - (IDW+1)'(NUM_IN);
    return sum[IDW-1:0];
  endfunction

  // Unpack flits and build the destination-filtered request vector.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flit[i] = in_data[i*WIDTH +: WIDTH];
      req[i]  = in_val[i] &&
                (flit[i][DEST_LSB +: DEST_WIDTH] == DEST_WIDTH'(MY_DEST));
    end
  end

  // Rotating priority: first request strictly after last_ptr, wrapping, so the
  // most recent winner is considered last.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      if (!found && req[wrap_add(last_ptr_q, k)]) begin
        winner = wrap_add(last_ptr_q, k);
        found  = 1'b1;
      end
    end
  end

  assign sel      = (state_q == ST_LOCKED) ? gnt_q : winner;
  assign hdr_len  = flit[winner][LEN_LSB +: LEN_WIDTH];
  assign out_data = flit[sel];
  assign grant_id = sel;
  assign locked   = (state_q == ST_LOCKED);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ptr_d = last_ptr_q;
    gnt_d      = gnt_q;
    out_val    = 1'b0;
    in_rdy     = '0;

    unique case (state_q)
      ST_IDLE: begin
        out_val = |req;
        if (|req) begin
          in_rdy[winner] = out_rdy;
          // Pointer only moves once the header is actually accepted.
          if (out_rdy) begin
            last_ptr_d = winner;
            cnt_d      = hdr_len;
            if (hdr_len != '0) begin
              state_d = ST_LOCKED;
              gnt_d   = winner;
            end
          end
        end
      end
      ST_LOCKED: begin
        // Body flits carry no destination; follow the owner blindly.
        out_val       = in_val[gnt_q];
        in_rdy[gnt_q] = out_rdy;
        if (in_val[gnt_q] && out_rdy) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshakes are suppressed for as long as reset is asserted.
    if (!rst_n) begin
      out_val = 1'b0;
      in_rdy  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_ptr_q <= IDW'(NUM_IN - 1);
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ptr_q <= last_ptr_d;
      gnt_q      <= gnt_d;
    end
  end

`ifdef IO_XBAR_ARB_WATCHDOG_EN
  logic [WDOG_BITS-1:0] wdog_q, wdog_d;
  logic                 wdog_err_q, wdog_err_d;

  // Counts stalled LOCKED cycles, saturating at all-ones; the error is sticky.
  always_comb begin
    wdog_d     = wdog_q;
    wdog_err_d = wdog_err_q | (&wdog_q);
    if (state_q == ST_IDLE || (out_val && out_rdy)) begin
      wdog_d = '0;
    end else if (!(&wdog_q)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: doc/io_xbar_out_arb.md
# io_xbar_out_arb

Round-robin output-port arbiter for the chipset I/O crossbar. It watches NUM_IN input ports, selects only those whose head flit is addressed to this output (MY_DEST), and grants the shared output port to one of them. The grant is held for a whole packet (header plus payload flits), so packets are never interleaved. One instance sits in front of each crossbar output, between the per-input destination compare and the output register slice.

## Interface
Parameters:
- NUM_IN, 4: number of competing input ports (2..8).
- WIDTH, 64: flit width.
- DEST_LSB, 50: LSB of the destination field in a header flit.
- DEST_WIDTH, 8: destination field width.
- MY_DEST, 0: destination code served by this output.
- LEN_LSB, 22: LSB of the payload-length field in a header flit.
- LEN_WIDTH, 8: payload-length field width, counted in flits that follow the header.
- WDOG_BITS, 10: watchdog counter width (used only with the macro).

Ports:
- clk, in, 1: clock; all state is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- in_data, in, NUM_IN*WIDTH: input flits; port i occupies bits [i*WIDTH +: WIDTH].
- in_val, in, NUM_IN: per-input flit valid.
- in_rdy, out, NUM_IN: per-input flit accept.
- out_data, out, WIDTH: selected flit.
- out_val, out, 1: output flit valid.
- out_rdy, in, 1: downstream accept.
- grant_id, out, $clog2(NUM_IN): current or winning input index.
- locked, out, 1: high while a packet's payload is in flight.
- wdog_err, out, 1: sticky stall error; tied 0 when the watchdog is not compiled in.

## Operation
- Transfer rule: a flit moves on any cycle where valid and ready are both high.
- Request vector:
  - IDLE: req[i] = in_val[i] & (in_data[i][DEST_LSB +: DEST_WIDTH] == MY_DEST).
  - LOCKED: requests are ignored.
- FSM states IDLE and LOCKED.
- IDLE:
  - The winner is the first set req[i] scanning from (last_ptr+1) mod NUM_IN upward, wrapping.
  - out_data = in_data[winner], out_val = |req, in_rdy[winner] = out_rdy; all other in_rdy are 0.
  - On header transfer, last_ptr <= winner and cnt <= header length field.
  - If length != 0, go to LOCKED with gnt <= winner.
  - If length == 0, stay in IDLE; a single-flit packet is complete.
  - If no header transfers (out_rdy low), last_ptr is not updated and the winner is re-evaluated next cycle. Arbitration is not sticky before the header is accepted.
- LOCKED:
  - out_data = in_data[gnt], out_val = in_val[gnt], in_rdy[gnt] = out_rdy; all other in_rdy are 0.
  - The destination is not checked on body flits.
  - Each body transfer decrements cnt. A transfer with cnt == 1 returns to IDLE. That cycle, the next header is not arbitrated; arbitration resumes the following cycle.
- grant_id = winner in IDLE, gnt in LOCKED. locked = (state == LOCKED).
- No input is ever starved: after input i sends a header, every other requesting input gets a turn before i wins again.

## Timing
- Data path is combinational: zero-cycle latency from in_* to out_*, and from out_rdy to in_rdy.
- State, cnt, last_ptr, gnt and watchdog update on the clk edge.
- Reset (rst_n low at an edge):
  - state <= IDLE, cnt <= 0, last_ptr <= NUM_IN-1 (input 0 has highest initial priority), gnt <= 0, wdog_err <= 0.
  - While rst_n is low, out_val and all in_rdy are forced to 0. Reset mid-packet drops the lock; the remaining body flits are later seen as headers (upstream resets together).
- Maximum length 2^LEN_WIDTH-1 flits. cnt is LEN_WIDTH bits wide and never wraps below 1 inside LOCKED.
- Simultaneous requests on the same cycle are resolved purely by the rotating priority.

## Configuration
- IO_XBAR_ARB_WATCHDOG_EN defined:
  - A WDOG_BITS counter clears on any output transfer or in IDLE, and increments each LOCKED cycle with no transfer.
  - When the counter saturates at all-ones, wdog_err sets and stays set until reset. Arbitration behaviour is unchanged.
- Not defined: no counter logic; wdog_err = 0 constant.

## Test plan
- Single header, dest match, len 0, out_rdy=1, input 2 valid → out_val=1 same cycle, in_rdy=4'b0100, FSM stays IDLE, last_ptr=2.
- All 4 inputs request len-0 headers continuously → grant order 0,1,2,3,0 over 5 cycles.
- Input 1 sends header len 3 while input 0 also requests → 4 consecutive input-1 flits; in_rdy[0]=0 throughout; input 0 granted on the cycle after the last body flit.
- Header dest ≠ MY_DEST on input 3, no other requests → out_val=0, in_rdy=0.
- out_rdy held 0 for 5 cycles mid-packet (cnt=2) → no decrement, lock held; resume → 2 transfers, then IDLE.
- Watchdog (macro on, WDOG_BITS=4): LOCKED with in_val[gnt]=0 for 15 cycles → wdog_err=1, held after traffic resumes; reset → 0. Macro off, same stimulus → wdog_err stays 0.
